// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of the single-port DMEM.
// Registered mem_* outputs; one-cycle ack with captured read data per port.
module dmem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_read_write,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [DATA_W-1:0] m0_data_in,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_data_out,
  input  logic              m1_req,
  input  logic              m1_read_write,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [DATA_W-1:0] m1_data_in,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_data_out,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_write,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_dataOut,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_e            state_q;
  logic              gnt_q;
  logic              last_q;
  logic [2:0]        cnt_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ack0_q;
  logic              ack1_q;
  logic [DATA_W-1:0] rd0_q;
  logic [DATA_W-1:0] rd1_q;
  logic              busy_q;
  logic              gnt_d;

  // 1 selects M1; on a tie the port not granted last time wins
  assign gnt_d = (m0_req && m1_req) ? ~last_q : m1_req;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            gnt_q   <= gnt_d;
            last_q  <= gnt_d;
            rw_q    <= gnt_d ? m1_read_write : m0_read_write;
            addr_q  <= gnt_d ? m1_address : m0_address;
            wdata_q <= gnt_d ? m1_data_in : m0_data_in;
            busy_q  <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!rw_q || RD_LAT == 1) begin
            rw_q    <= 1'b1;
            ack0_q  <= ~gnt_q;
            ack1_q  <= gnt_q;
            state_q <= S_RESP;
            if (rw_q && !gnt_q) rd0_q <= mem_dataOut;
            if (rw_q && gnt_q) rd1_q <= mem_dataOut;
          end else begin
            cnt_q   <= CNT_INIT;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 3'd1) begin
            ack0_q  <= ~gnt_q;
            ack1_q  <= gnt_q;
            state_q <= S_RESP;
            if (!gnt_q) rd0_q <= mem_dataOut;
            if (gnt_q) rd1_q <= mem_dataOut;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_RESP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m0_ack         = ack0_q;
  assign m1_ack         = ack1_q;
  assign m0_data_out    = rd0_q;
  assign m1_data_out    = rd1_q;
  assign mem_address    = addr_q;
  assign mem_read_write = rw_q;
  assign mem_data_in    = wdata_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a DMEM model and a reference
// memory feeding a scoreboard of expected acks, latencies and read data.
module tb_dmem_arbiter;

  localparam int RD_LAT = 1;

  typedef struct {
    bit          p;
    bit          rd;
    logic [15:0] data;
    int          lat;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        m0_req, m0_rw, m0_ack;
  logic [12:0] m0_addr;
  logic [15:0] m0_din, m0_dout;
  logic        m1_req, m1_rw, m1_ack;
  logic [12:0] m1_addr;
  logic [15:0] m1_din, m1_dout;
  logic [12:0] mem_address;
  logic        mem_read_write;
  logic [15:0] mem_data_in, mem_dataOut;
  logic        busy;

  logic        c_req, c_ack, c_busy, c_mrw;
  logic [12:0] c_addr, c_maddr;
  logic [15:0] c_dout, c_mdin, c_mdout, c_p1, c_p2;
  logic        c_ack1;
  logic [15:0] c_dout1;

  logic [15:0] dmem    [0:8191];
  logic [15:0] ref_mem [0:8191];
  exp_t        sb [$];
  int          tests = 0;
  int          fails = 0;

  dmem_arbiter #(.DATA_W(16), .ADDR_W(13), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_read_write(m0_rw), .m0_address(m0_addr),
    .m0_data_in(m0_din), .m0_ack(m0_ack), .m0_data_out(m0_dout),
    .m1_req(m1_req), .m1_read_write(m1_rw), .m1_address(m1_addr),
    .m1_data_in(m1_din), .m1_ack(m1_ack), .m1_data_out(m1_dout),
    .mem_address(mem_address), .mem_read_write(mem_read_write),
    .mem_data_in(mem_data_in), .mem_dataOut(mem_dataOut), .busy(busy)
  );

  dmem_arbiter #(.DATA_W(16), .ADDR_W(13), .RD_LAT(3)) dut3 (
    .clock(clock), .reset(reset),
    .m0_req(c_req), .m0_read_write(1'b1), .m0_address(c_addr),
    .m0_data_in(16'h0000), .m0_ack(c_ack), .m0_data_out(c_dout),
    .m1_req(1'b0), .m1_read_write(1'b1), .m1_address(13'h0000),
    .m1_data_in(16'h0000), .m1_ack(c_ack1), .m1_data_out(c_dout1),
    .mem_address(c_maddr), .mem_read_write(c_mrw),
    .mem_data_in(c_mdin), .mem_dataOut(c_mdout), .busy(c_busy)
  );

  function automatic logic [15:0] init_val(input int i);
    return 16'((i * 37 + 1) ^ 16'h3C00);
  endfunction

  function automatic logic [15:0] rom3(input logic [12:0] a);
    return {3'b000, a} ^ 16'h5A00;
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Zero-latency DMEM for RD_LAT=1; writes land on the edge closing ISSUE
  initial begin
    for (int i = 0; i < 8192; i++) dmem[i] = init_val(i);
    forever begin
      @(posedge clock);
      if (mem_read_write === 1'b0) dmem[mem_address] <= mem_data_in;
    end
  end
  assign mem_dataOut = dmem[mem_address];

  // Two-register read pipe: data is only correct after three cycles
  always @(posedge clock) begin
    c_p1 <= rom3(c_maddr);
    c_p2 <= c_p1;
  end
  assign c_mdout = c_p2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic xact(input bit p, input bit rd, input logic [12:0] a,
                      input logic [15:0] d);
    exp_t e;
    int   n;
    bit   got;
    e.p    = p;
    e.rd   = rd;
    e.data = rd ? ref_mem[a] : d;
    e.lat  = rd ? RD_LAT + 1 : 2;
    if (!rd) ref_mem[a] = d;
    sb.push_back(e);
    @(negedge clock);
    if (p) begin
      m1_req = 1'b1; m1_rw = rd; m1_addr = a; m1_din = d;
    end else begin
      m0_req = 1'b1; m0_rw = rd; m0_addr = a; m0_din = d;
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        chk("issue_addr", 32'(mem_address), 32'(a));
        chk("issue_rw", 32'(mem_read_write), 32'(rd));
      end
      got = p ? m1_ack : m0_ack;
    end
    if (p) m1_req = 1'b0;
    else m0_req = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
    if (got) begin
      e = sb.pop_front();
      chk("ack_latency", 32'(n), 32'(e.lat));
      if (e.rd) chk("rd_data", 32'(p ? m1_dout : m0_dout), 32'(e.data));
    end
  endtask

  initial begin
    int          k;
    int          n;
    int          acks;
    int          since;
    bit          first;
    logic [12:0] a;
    logic [15:0] old;
    reset  = 1'b0;
    m0_req = 1'b0; m0_rw = 1'b1; m0_addr = '0; m0_din = '0;
    m1_req = 1'b0; m1_rw = 1'b1; m1_addr = '0; m1_din = '0;
    c_req  = 1'b0; c_addr = '0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = init_val(i);
    #12;
    chk("rst_rw", 32'(mem_read_write), 32'd1);
    chk("rst_addr", 32'(mem_address), 32'd0);
    chk("rst_din", 32'(mem_data_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", 32'({m0_ack, m1_ack}), 32'd0);
    chk("rst_dout", 32'({m0_dout, m1_dout}), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // simultaneous reads right after reset: M0 first, then alternate
    @(negedge clock);
    m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 13'h0400;
    m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 13'h0800;
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(negedge clock);
      if (m0_ack || m1_ack) begin
        chk("rr_order", 32'({m0_ack, m1_ack}), (k % 2 == 0) ? 32'd2 : 32'd1);
        if (m0_ack) chk("rr_data0", 32'(m0_dout), 32'(ref_mem[13'h0400]));
        else chk("rr_data1", 32'(m1_dout), 32'(ref_mem[13'h0800]));
        k++;
        if (k == 4) begin
          m0_req = 1'b0;
          m1_req = 1'b0;
        end
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    chk("rr_count", 32'(k), 32'd4);

    xact(1'b0, 1'b0, 13'h0005, 16'hA5A5);
    xact(1'b0, 1'b1, 13'h0005, 16'h0000);

    for (int b = 0; b < 8; b++)
      xact(1'b1, 1'b0, {3'(b), 10'h3FF}, 16'(16'h1000 + b * 16'h0111));
    for (int b = 0; b < 8; b++)
      xact(1'b1, 1'b1, {3'(b), 10'h3FF}, 16'h0000);

    // reset lands in the ISSUE cycle of an M1 write
    a   = 13'h0123;
    old = ref_mem[a];
    @(negedge clock);
    m1_req = 1'b1; m1_rw = 1'b0; m1_addr = a; m1_din = 16'hDEAD;
    @(negedge clock);
    chk("abort_pre_rw", 32'(mem_read_write), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("abort_rw", 32'(mem_read_write), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    m1_req = 1'b0;
    @(negedge clock);
    chk("abort_ack", 32'(m1_ack), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_idle", 32'({busy, m1_ack}), 32'd0);
    xact(1'b1, 1'b1, a, 16'h0000);
    chk("abort_old", 32'(m1_dout), 32'(old));

    // M0 keeps req through the IDLE cycle after its ack
    @(negedge clock);
    m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 13'h0777;
    acks  = 0;
    since = 0;
    first = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (first) since++;
      if (since == 2) m0_req = 1'b0;
      if (m0_ack) begin
        acks++;
        first = 1'b1;
        chk("hold_data", 32'(m0_dout), 32'(ref_mem[13'h0777]));
      end
    end
    m0_req = 1'b0;
    chk("hold_acks", 32'(acks), 32'd2);

    do_reset();
    chk("do_reset_busy", 32'(busy), 32'd0);

    // RD_LAT=3 instance
    @(negedge clock);
    c_req  = 1'b1;
    c_addr = 13'h1ABC;
    n = 0;
    while (!c_ack && n < 20) begin
      @(negedge clock);
      n++;
      if (n <= 3) begin
        chk("l3_addr", 32'(c_maddr), 32'h1ABC);
        chk("l3_busy", 32'(c_busy), 32'd1);
        chk("l3_noack", 32'(c_ack), 32'd0);
      end
    end
    c_req = 1'b0;
    chk("l3_latency", 32'(n), 32'd4);
    chk("l3_busy_resp", 32'(c_busy), 32'd1);
    chk("l3_data", 32'(c_dout), 32'(rom3(13'h1ABC)));
    @(negedge clock);
    chk("l3_idle", 32'({c_busy, c_ack}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
